// File: rtl/forth_dbus_responder.sv
// Data-bus responder for the forth core: 128x16 data RAM below 0x80 and
// memory-mapped I/O (output FIFO, input holding register, cycle counter, timer) above.
module forth_dbus_responder #(
    parameter int OUT_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  daddr,
    input  logic [15:0] ddata_write,
    input  logic        dwrite,
    output logic [15:0] ddata_read,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready
);

    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [7:0] ADDR_OUT  = 8'h80;
    localparam logic [7:0] ADDR_STAT = 8'h81;
    localparam logic [7:0] ADDR_IN   = 8'h82;
    localparam logic [7:0] ADDR_CYC  = 8'h84;
    localparam logic [7:0] ADDR_TMR  = 8'h85;

    logic wr_ram, wr_out, wr_stat, wr_in, wr_cyc, wr_tmr;

    assign wr_ram  = dwrite && !daddr[7];
    assign wr_out  = dwrite && (daddr == ADDR_OUT);
    assign wr_stat = dwrite && (daddr == ADDR_STAT);
    assign wr_in   = dwrite && (daddr == ADDR_IN);
    assign wr_cyc  = dwrite && (daddr == ADDR_CYC);
    assign wr_tmr  = dwrite && (daddr == ADDR_TMR);

    logic [15:0] ram [128];

    // NOTE: storage arrays get no reset branch; clearing them would cost a write
    // port per word, and their contents are meant to survive a reset anyway.
    always_ff @(posedge clk) begin
        if (wr_ram) ram[daddr[6:0]] <= ddata_write;
    end

    logic [15:0]      fifo [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             out_full, out_ovf, push, pop;

    // Fullness is judged on the registered count, so a same-cycle pop cannot make room.
    assign out_full  = (count == CNT_W'(OUT_DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = fifo[rd_ptr];
    assign push      = wr_out && !out_full;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= ddata_write;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            out_ovf <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
            if (wr_out && out_full)              out_ovf <= 1'b1;
            else if (wr_stat && ddata_write[4])  out_ovf <= 1'b0;
        end
    end

    logic        in_full;
    logic [15:0] in_word;

    assign in_ready = !in_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_full <= 1'b0;
            in_word <= '0;
        end else if (in_full) begin
            if (wr_in) in_full <= 1'b0;
        end else if (in_valid) begin
            in_full <= 1'b1;
            in_word <= in_data;
        end
    end

    logic [15:0] cyc, tmr;
    logic        tmr_exp, tmr_expiring;

    // A load in the same cycle as 1->0 suppresses the expiry.
    assign tmr_expiring = !wr_tmr && (tmr == 16'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc     <= '0;
            tmr     <= '0;
            tmr_exp <= 1'b0;
        end else begin
            cyc <= wr_cyc ? ddata_write : cyc + 16'd1;
            if (wr_tmr)          tmr <= ddata_write;
            else if (tmr != '0)  tmr <= tmr - 16'd1;
            if (tmr_expiring)                   tmr_exp <= 1'b1;
            else if (wr_stat && ddata_write[5]) tmr_exp <= 1'b0;
        end
    end

    logic [3:0] stat_count;
    assign stat_count = 4'(count);

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        ddata_read = '0;
        if (!daddr[7]) begin
            ddata_read = ram[daddr[6:0]];
        end else begin
            case (daddr)
                ADDR_STAT: ddata_read = {8'h00, out_full, in_full, tmr_exp, out_ovf, stat_count};
                ADDR_IN:   ddata_read = in_full ? in_word : 16'h0000;
                ADDR_CYC:  ddata_read = cyc;
                ADDR_TMR:  ddata_read = tmr;
                default:   ddata_read = '0;
            endcase
        end
    end

endmodule
